mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port data `memory` between the CPU data port (M0) and an external program loader/debug port (M1). It sits between both requesters and the `memory` instance, and sequences every access through a request/grant handshake. Round-robin priority is held in a register, and read data returns with a registered acknowledge one cycle after the grant. An optional lock lets one master own the memory across back-to-back transfers.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req` / `m1_req` in 1: access request; the master holds it and its fields stable until granted.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_address` / `m1_address` in ADDR_WIDTH: access address.
- `m0_data_in` / `m1_data_in` in DATA_WIDTH: write data.
- `m0_lock` / `m1_lock` in 1: hold ownership after this access. Present only with `MEM_ARB_LOCK_EN`.
- `m0_gnt` / `m1_gnt` out 1: access is performed this cycle. Combinational.
- `m0_rvalid` / `m1_rvalid` out 1: read data valid. Registered.
- `m0_data_out` / `m1_data_out` out DATA_WIDTH: read data. Registered.
- `mem_we` out 1: to `memory.we`.
- `mem_address` out ADDR_WIDTH: to `memory.address`.
- `mem_data_in` out DATA_WIDTH: to `memory.data_in`.
- `mem_data_out` in DATA_WIDTH: from `memory.data_out` (combinational read).

## Operation
- At most one grant per cycle. The granted master's `we`, `address` and `data_in` are driven onto `mem_*`.
- With no grant, `mem_we`, `mem_address` and `mem_data_in` are all 0.
- Priority register `last` records the master granted most recently.
  - Both masters requesting: grant the master ≠ `last`.
  - One master requesting: grant that master.
  - `last` updates on every grant.
- Write: the memory commits at the clock edge ending the grant cycle. No `rvalid`.
- Read: `mem_data_out` is captured into the granted master's `data_out` register. That master's `rvalid` is 1 for exactly the next cycle.
- `mX_data_out` holds its last read value until the next read by that master.
- A master may re-request in the cycle its `rvalid` is high. Its new grant competes normally.
- No combinational path from `mem_data_out` to any output.
- Lock state machine (`MEM_ARB_LOCK_EN` only). States: UNLOCKED, LOCKED_M0, LOCKED_M1.
  - UNLOCKED → LOCKED_Mx: Mx is granted with `mx_lock`=1.
  - LOCKED_Mx → UNLOCKED: Mx is granted with `mx_lock`=0, or Mx deasserts `req` for a cycle.
  - While LOCKED_Mx, only Mx may be granted. The other master waits; its `req` stays pending.

## Timing
- Reset values:
  - `last` = M1, so M0 wins the first tie.
  - Lock state = UNLOCKED.
  - All `rvalid` = 0; all `data_out` = 0.
  - Gnt and mem outputs follow the combinational rules above.
- Grant latency: same cycle as `req` when uncontended.
- Read latency: `rvalid`/`data_out` one cycle after `gnt`.
- Throughput: one access per cycle.
- Contention: two continuously requesting masters alternate every cycle (unlocked).
- Reset asserted mid-operation:
  - Clears lock and `rvalid` at that edge.
  - A read granted in the reset cycle returns no `rvalid`.
  - A write granted in the reset cycle is still presented to memory. Memory reset takes precedence.
- Simultaneous release and request: when the lock owner releases, the other master can be granted in the next cycle.

## Configuration
- `MEM_ARB_LOCK_EN` defined: `m*_lock` ports and the lock FSM are compiled in.
- `MEM_ARB_LOCK_EN` undefined:
  - Lock ports are absent.
  - The lock state is permanently UNLOCKED.
  - Arbitration is pure round-robin.

## Structure
- Shared package `risc_v_pkg` holds:
  - Master index constants `MEM_ARB_M0` = 0 and `MEM_ARB_M1` = 1.
  - Lock state typedef `mem_arb_lock_t` (UNLOCKED, LOCKED_M0, LOCKED_M1).
- Sub-module `rr_picker`: combinational two-way round-robin selector. Inputs: req vector, `last`, lock state. Output: one-hot grant.
- Registers, muxing and the response path stay in `mem_arbiter`.

## Test plan
- Reset, then M0 reads 0x10 while memory holds 0xDEADBEEF → `m0_gnt`=1 in the same cycle; next cycle `m0_rvalid`=1, `m0_data_out`=0xDEADBEEF; M1 outputs untouched.
- Both masters request reads every cycle for 4 cycles → grants go M0, M1, M0, M1; `rvalid` trails each grant by one cycle.
- M1 writes 0x12345678 to 0x20, then M0 reads 0x20 → `m0_data_out`=0x12345678; `m1_rvalid` never asserts.
- (LOCK_EN) M1 is granted with `m1_lock`=1 for 3 cycles while M0 requests → `m0_gnt`=0 throughout; M1 then is granted with `m1_lock`=0 → M0 is granted in the following cycle.
- Reset asserted in the cycle after an M0 read grant, while locked → `m0_rvalid`=0, lock cleared, `data_out` = 0, and the next tie is granted to M0.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared definitions for the data-memory arbiter: master indices and the lock state type.
package risc_v_pkg;

  localparam logic MEM_ARB_M0 = 1'b0;
  localparam logic MEM_ARB_M1 = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED_M0 = 2'd1,
    LOCKED_M1 = 2'd2
  } mem_arb_lock_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational two-way round-robin selector; a held lock restricts the grant to its owner.
module rr_picker
  import risc_v_pkg::*;
(
  input  logic [1:0]    i_req,
  input  logic          i_last,
  input  mem_arb_lock_t i_lock,
  output logic [1:0]    o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_lock)
      LOCKED_M0: o_gnt[0] = i_req[0];
      LOCKED_M1: o_gnt[1] = i_req[1];
      default: begin
        // On a tie the master that did not go last wins.
        if (&i_req) o_gnt = (i_last == MEM_ARB_M1) ? 2'b01 : 2'b10;
        else        o_gnt = i_req;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single-port data memory (CPU port M0, loader/debug port M1).
// Define MEM_ARB_LOCK_EN to compile in the m*_lock ports and the ownership lock FSM.
module mem_arbiter
  import risc_v_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_data_in,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_data_in,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_data_out,
  output logic [DATA_WIDTH-1:0] m1_data_out,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  logic [1:0]            w_gnt;
  logic                  r_last;
  mem_arb_lock_t         w_lock;
  logic [1:0]            r_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_dout;
  logic [DATA_WIDTH-1:0] r_m1_dout;

  rr_picker u_pick (
    .i_req  ({m1_req, m0_req}),
    .i_last (r_last),
    .i_lock (w_lock),
    .o_gnt  (w_gnt)
  );

`ifdef MEM_ARB_LOCK_EN
  mem_arb_lock_t r_lock;
  mem_arb_lock_t w_lock_nxt;

  always_ff @(posedge clock) begin
    if (reset) r_lock <= UNLOCKED;
    else       r_lock <= w_lock_nxt;
  end

  // Owner releases by a grant without lock, or by dropping req for a cycle.
  always_comb begin
    w_lock_nxt = r_lock;
    case (r_lock)
      UNLOCKED: begin
        if (w_gnt[0] && m0_lock)      w_lock_nxt = LOCKED_M0;
        else if (w_gnt[1] && m1_lock) w_lock_nxt = LOCKED_M1;
      end
      LOCKED_M0: if (!m0_req || (w_gnt[0] && !m0_lock)) w_lock_nxt = UNLOCKED;
      LOCKED_M1: if (!m1_req || (w_gnt[1] && !m1_lock)) w_lock_nxt = UNLOCKED;
      default:   w_lock_nxt = UNLOCKED;
    endcase
  end

  assign w_lock = r_lock;
`else
  assign w_lock = UNLOCKED;
`endif

  always_ff @(posedge clock) begin
    if (reset)         r_last <= MEM_ARB_M1;
    else if (|w_gnt)   r_last <= w_gnt[1];
  end

  always_comb begin
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if (w_gnt[0]) begin
      mem_we      = m0_we;
      mem_address = m0_address;
      mem_data_in = m0_data_in;
    end else if (w_gnt[1]) begin
      mem_we      = m1_we;
      mem_address = m1_address;
      mem_data_in = m1_data_in;
    end
  end

  // Read data is registered so nothing downstream sees a combinational memory path.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid  <= 2'b00;
      r_m0_dout <= '0;
      r_m1_dout <= '0;
    end else begin
      r_rvalid <= w_gnt & {~m1_we, ~m0_we};
      if (w_gnt[0] && !m0_we) r_m0_dout <= mem_data_out;
      if (w_gnt[1] && !m1_we) r_m1_dout <= mem_data_out;
    end
  end

  assign m0_gnt      = w_gnt[0];
  assign m1_gnt      = w_gnt[1];
  assign m0_rvalid   = r_rvalid[0];
  assign m1_rvalid   = r_rvalid[1];
  assign m0_data_out = r_m0_dout;
  assign m1_data_out = r_m1_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m0_lock, m1_lock;
  logic [31:0] m0_address, m0_data_in, m1_address, m1_data_in;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_data_out, m1_data_out, mem_address, mem_data_in, mem_data_out;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  always #5 clock = ~clock;

  assign mem_data_out = mem[mem_address[7:0]];
  always @(posedge clock) if (mem_we) mem[mem_address[7:0]] <= mem_data_in;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_address   (m0_address),
    .m0_data_in   (m0_data_in),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_address   (m1_address),
    .m1_data_in   (m1_data_in),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock      (m0_lock),
    .m1_lock      (m1_lock),
`endif
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .m0_rvalid    (m0_rvalid),
    .m1_rvalid    (m1_rvalid),
    .m0_data_out  (m0_data_out),
    .m1_data_out  (m1_data_out),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Reference model state: who went last, who owns the lock (-1 none), expected responses.
  int          checks = 0;
  int          errors = 0;
  int          last_m;
  int          owner;
  bit [1:0]    e_rv;
  logic [31:0] e_dout [2];
  bit          eg0, eg1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict and compare outputs, cross the edge, advance the model.
  task automatic cyc();
    bit r0, r1;
    logic [31:0] ea, ed;
    bit ewe;
    #1;
    r0 = m0_req; r1 = m1_req;
    eg0 = 0; eg1 = 0;
    if (owner == 0)           eg0 = r0;
    else if (owner == 1)      eg1 = r1;
    else if (r0 && r1)        begin if (last_m == 1) eg0 = 1; else eg1 = 1; end
    else                      begin eg0 = r0; eg1 = r1; end
    ewe = 0; ea = 0; ed = 0;
    if (eg0)      begin ewe = m0_we; ea = m0_address; ed = m0_data_in; end
    else if (eg1) begin ewe = m1_we; ea = m1_address; ed = m1_data_in; end
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("mem_we", mem_we, ewe);
    chk("mem_address", mem_address, ea);
    chk("mem_data_in", mem_data_in, ed);
    chk("m0_rvalid", m0_rvalid, e_rv[0]);
    chk("m1_rvalid", m1_rvalid, e_rv[1]);
    chk("m0_data_out", m0_data_out, e_dout[0]);
    chk("m1_data_out", m1_data_out, e_dout[1]);
    @(posedge clock);
    if (ewe) ref_mem[ea[7:0]] = ed;
    if (reset) begin
      last_m = 1; owner = -1; e_rv = 0; e_dout[0] = 0; e_dout[1] = 0;
    end else begin
      e_rv = {eg1 && !m1_we, eg0 && !m0_we};
      if (e_rv[0]) e_dout[0] = ref_mem[m0_address[7:0]];
      if (e_rv[1]) e_dout[1] = ref_mem[m1_address[7:0]];
      if (eg0) last_m = 0;
      if (eg1) last_m = 1;
      if (LOCK_EN) begin
        if (owner == -1) begin
          if (eg0 && m0_lock)      owner = 0;
          else if (eg1 && m1_lock) owner = 1;
        end else if (owner == 0) begin
          if (!r0 || (eg0 && !m0_lock)) owner = -1;
        end else begin
          if (!r1 || (eg1 && !m1_lock)) owner = -1;
        end
      end
    end
    #1;
  endtask

  task automatic m0(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d, input bit lk);
    m0_req = rq; m0_we = we; m0_address = a; m0_data_in = d; m0_lock = lk;
  endtask

  task automatic m1(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d, input bit lk);
    m1_req = rq; m1_we = we; m1_address = a; m1_data_in = d; m1_lock = lk;
  endtask

  task automatic do_reset();
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    reset = 1; cyc(); cyc(); reset = 0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1;
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    last_m = 1; owner = -1; e_rv = 0; e_dout[0] = 0; e_dout[1] = 0;
    @(posedge clock); #1;
    do_reset();

    // Uncontended read: same-cycle grant, data one cycle later.
    m0(1, 0, 32'h10, 0, 0);
    #1 chk("t1_gnt", m0_gnt, 1);
    cyc();
    m0(0, 0, 0, 0, 0);
    #1;
    chk("t1_rvalid", m0_rvalid, 1);
    chk("t1_dout", m0_data_out, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_m1_dout", m1_data_out, 0);
    cyc();

    // Continuous contention alternates M0, M1, M0, M1.
    do_reset();
    m0(1, 0, 32'h1, 0, 0); m1(1, 0, 32'h2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_g0", m0_gnt, (i % 2) == 0);
      chk("t2_g1", m1_gnt, (i % 2) == 1);
      if (i > 0) chk("t2_rv0", m0_rvalid, ((i - 1) % 2) == 0);
      cyc();
    end
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    #1 chk("t2_rv1", m1_rvalid, 1);
    cyc();

    // Write by M1 is seen by a later M0 read.
    do_reset();
    m1(1, 1, 32'h20, 32'h12345678, 0);
    cyc();
    m1(0, 0, 0, 0, 0); m0(1, 0, 32'h20, 0, 0);
    #1 chk("t3_m1_rv", m1_rvalid, 0);
    cyc();
    m0(0, 0, 0, 0, 0);
    #1;
    chk("t3_dout", m0_data_out, 32'h12345678);
    chk("t3_m1_rv2", m1_rvalid, 0);
    cyc();

`ifdef MEM_ARB_LOCK_EN
    // M1 owns the memory for three locked accesses, then releases.
    do_reset();
    m1(1, 0, 32'h6, 0, 1);
    cyc();
    m0(1, 0, 32'h5, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t4_m0_blocked", m0_gnt, 0);
      cyc();
    end
    m1(1, 0, 32'h7, 0, 0);
    #1 chk("t4_release_blk", m0_gnt, 0);
    cyc();
    m1(0, 0, 0, 0, 0);
    #1 chk("t4_m0_after", m0_gnt, 1);
    cyc();
    m0(0, 0, 0, 0, 0);
    cyc();
`endif

    // Reset right after a (locked) M0 read grant.
    do_reset();
    m0(1, 0, 32'h10, 0, LOCK_EN); m1(1, 0, 32'h11, 0, 0);
    cyc();
    m0(1, 0, 32'h12, 0, LOCK_EN);
    reset = 1;
    cyc();
    reset = 0;
    #1;
    chk("t5_rvalid", m0_rvalid, 0);
    chk("t5_dout", m0_data_out, 0);
    chk("t5_tie_m0", m0_gnt, 1);
    cyc();
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    cyc();

    // Randomized traffic; requests hold until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!m0_req || eg0) begin
        if ($urandom % 3 != 0) m0(1, 1'($urandom), 32'($urandom % 16), $urandom, ($urandom % 4) == 0);
        else                   m0(0, 0, 0, 0, 0);
      end
      if (!m1_req || eg1) begin
        if ($urandom % 3 != 0) m1(1, 1'($urandom), 32'($urandom % 16), $urandom, ($urandom % 4) == 0);
        else                   m1(0, 0, 0, 0, 0);
      end
      reset = ($urandom % 150) == 0;
      cyc();
    end
    reset = 0;
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
